// File: rtl/router_pkg.sv
// router_pkg: shared byte width, header field positions and FSM state encoding for the 1x3 router.
package router_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 1;
   localparam int LEN_LSB = 2;
   localparam logic [1:0] INVALID_ADDR = 2'b11;
   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      LOAD_PARITY,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      CHECK_PARITY_ERROR,
      WAIT_TILL_EMPTY
   } router_state_t;
endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk: accumulates packet parity, latches the trailing parity byte and flags a mismatch.
module router_parity_chk import router_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] header_reg,
   input  logic              parity_done,
   output logic              err
);
   logic [DATA_W-1:0] int_parity;
   logic [DATA_W-1:0] ext_parity;
   // bytes parked in full_hold were already folded in on their ld_state cycle
   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_parity <= '0;
         ext_parity <= '0;
         err        <= 1'b0;
      end else if (detect_add) begin
         int_parity <= '0;
         ext_parity <= '0;
         err        <= 1'b0;
      end else begin
         if (lfd_state)
            int_parity <= int_parity ^ header_reg;
         else if (ld_state && pkt_valid)
            int_parity <= int_parity ^ data_in;
         if (ld_state && !pkt_valid)
            ext_parity <= data_in;
         if (parity_done && int_parity != ext_parity)
            err <= 1'b1;
      end
   end
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath register stage (header latch, FIFO-full byte hold, parity handshake).
// Optional payload length check: define ROUTER_REG_LEN_CHECK_EN to add the len_err output.
module router_reg import router_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_pkt_valid,
   output logic              err
`ifdef ROUTER_REG_LEN_CHECK_EN
   ,
   output logic              len_err
`endif
);
   logic [DATA_W-1:0] header_reg;
   logic [DATA_W-1:0] full_hold;
   logic              hdr_ld;
   logic              pd_set;
   logic              unused;
   // full_state only means "hold everything", which is the default behaviour
   assign unused = full_state;
   assign hdr_ld = detect_add && pkt_valid && data_in[ADDR_MSB:ADDR_LSB] != INVALID_ADDR;
   assign pd_set = (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done);
   always_ff @(posedge clock) begin
      if (!resetn)
         header_reg <= '0;
      else if (hdr_ld)
         header_reg <= data_in;
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         dout      <= '0;
         full_hold <= '0;
      end else if (lfd_state)
         dout <= header_reg;
      else if (ld_state && !fifo_full)
         dout <= data_in;
      else if (ld_state)
         full_hold <= data_in;
      else if (laf_state)
         dout <= full_hold;
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         low_pkt_valid <= 1'b0;
         parity_done   <= 1'b0;
      end else begin
         low_pkt_valid <= (ld_state && !pkt_valid) ? 1'b1 : rst_int_reg ? 1'b0 : low_pkt_valid;
         parity_done   <= pd_set ? 1'b1 : detect_add ? 1'b0 : parity_done;
      end
   end
   router_parity_chk #(.DATA_W(DATA_W)) u_parity (
      .clock      (clock),
      .resetn     (resetn),
      .detect_add (detect_add),
      .lfd_state  (lfd_state),
      .ld_state   (ld_state),
      .pkt_valid  (pkt_valid),
      .data_in    (data_in),
      .header_reg (header_reg),
      .parity_done(parity_done),
      .err        (err)
   );
`ifdef ROUTER_REG_LEN_CHECK_EN
   localparam int CW = DATA_W - LEN_LSB;
   logic [CW-1:0] count;
   always_ff @(posedge clock) begin
      if (!resetn) begin
         count   <= '0;
         len_err <= 1'b0;
      end else if (detect_add) begin
         count   <= '0;
         len_err <= 1'b0;
      end else begin
         if (ld_state && pkt_valid)
            count <= count + CW'(1);
         if (pd_set)
            len_err <= count != header_reg[DATA_W-1:LEN_LSB];
      end
   end
`endif
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed packets with hand-computed expectations, checked by a queue-driven monitor.
module tb_router_reg;
   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       fifo_full = 1'b0;
   logic [5:0] st = 6'b0;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
   logic [7:0] dout;
   logic       parity_done, low_pkt_valid, err, le_act;
   assign {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
   localparam logic [5:0] NO = 6'b000000, DA = 6'b100000, LFD = 6'b010000, LD = 6'b001000,
                          LAF = 6'b000100, FS = 6'b000010, RIR = 6'b000001;
   typedef struct packed {
      logic [7:0] dout;
      logic       pd;
      logic       lpv;
      logic       err;
      logic [7:0] hdr;
      logic       le;
   } obs_t;
   typedef struct {
      string nm;
      obs_t  o;
   } exp_t;
   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   always #5 clock = ~clock;
`ifdef ROUTER_REG_LEN_CHECK_EN
   logic len_err;
   assign le_act = len_err;
`else
   assign le_act = 1'b0;
`endif
   router_reg dut (
      .clock        (clock),
      .resetn       (resetn),
      .pkt_valid    (pkt_valid),
      .data_in      (data_in),
      .fifo_full    (fifo_full),
      .detect_add   (detect_add),
      .lfd_state    (lfd_state),
      .ld_state     (ld_state),
      .laf_state    (laf_state),
      .full_state   (full_state),
      .rst_int_reg  (rst_int_reg),
      .dout         (dout),
      .parity_done  (parity_done),
      .low_pkt_valid(low_pkt_valid),
      .err          (err)
`ifdef ROUTER_REG_LEN_CHECK_EN
      ,
      .len_err      (len_err)
`endif
   );
   task automatic step(input string nm, input logic rn, input logic [5:0] s, input logic pv,
                       input logic [7:0] d, input logic ff, input logic [7:0] xd, input logic xpd,
                       input logic xlpv, input logic xerr, input logic [7:0] xhdr, input logic xle);
      exp_t e;
      @(negedge clock);
      resetn = rn;
      st = s;
      pkt_valid = pv;
      data_in = d;
      fifo_full = ff;
      e.nm = nm;
      e.o = {xd, xpd, xlpv, xerr, xhdr, xle};
      q.push_back(e);
   endtask
   // monitor: one expectation per driven cycle, compared just after the edge it describes
   always @(posedge clock) begin
      exp_t m;
      obs_t a;
      #1;
      if (q.size() != 0) begin
         m = q.pop_front();
         a = {dout, parity_done, low_pkt_valid, err, dut.header_reg, le_act};
`ifndef ROUTER_REG_LEN_CHECK_EN
         m.o.le = 1'b0;
`endif
         checks++;
         if (a !== m.o) begin
            failures++;
            $display("FAIL %s: got dout=%h pd=%b lpv=%b err=%b hdr=%h len_err=%b, want dout=%h pd=%b lpv=%b err=%b hdr=%h len_err=%b",
                     m.nm, a.dout, a.pd, a.lpv, a.err, a.hdr, a.le,
                     m.o.dout, m.o.pd, m.o.lpv, m.o.err, m.o.hdr, m.o.le);
         end
      end
   end
   initial begin
      //    name        rn st   pv data   ff  dout  pd lpv err hdr   le
      step("reset",     0, NO,  0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0);
      step("g_hdr",     1, DA,  1, 8'h0D, 0, 8'h00, 0, 0, 0, 8'h0D, 0);
      step("g_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("g_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("g_p1",      1, LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 8'h0D, 0);
      step("g_p2",      1, LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0, 8'h0D, 0);
      step("g_par",     1, LD,  0, 8'h9B, 0, 8'h9B, 1, 1, 0, 8'h0D, 0);
      step("g_chk",     1, RIR, 0, 8'h9B, 0, 8'h9B, 1, 0, 0, 8'h0D, 0);
      step("b_hdr",     1, DA,  1, 8'h0D, 0, 8'h9B, 0, 0, 0, 8'h0D, 0);
      step("b_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("b_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("b_p1",      1, LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 8'h0D, 0);
      step("b_p2",      1, LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0, 8'h0D, 0);
      step("b_par",     1, LD,  0, 8'h9A, 0, 8'h9A, 1, 1, 0, 8'h0D, 0);
      step("b_err",     1, RIR, 0, 8'h9A, 0, 8'h9A, 1, 0, 1, 8'h0D, 0);
      step("b_sticky",  1, NO,  0, 8'h00, 0, 8'h9A, 1, 0, 1, 8'h0D, 0);
      step("f_hdr_clr", 1, DA,  1, 8'h0D, 0, 8'h9A, 0, 0, 0, 8'h0D, 0);
      step("f_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("f_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("f_p1_full", 1, LD,  1, 8'h3C, 1, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("f_fs",      1, FS,  1, 8'h0F, 1, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("f_laf",     1, LAF, 1, 8'h0F, 0, 8'h3C, 0, 0, 0, 8'h0D, 0);
      step("f_p2",      1, LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0, 8'h0D, 0);
      step("f_par",     1, LD,  0, 8'h9B, 0, 8'h9B, 1, 1, 0, 8'h0D, 0);
      step("f_chk",     1, RIR, 0, 8'h9B, 0, 8'h9B, 1, 0, 0, 8'h0D, 0);
      step("q_hdr",     1, DA,  1, 8'h0D, 0, 8'h9B, 0, 0, 0, 8'h0D, 0);
      step("q_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("q_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("q_p1",      1, LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 8'h0D, 0);
      step("q_p2",      1, LD,  1, 8'h0F, 0, 8'h0F, 0, 0, 0, 8'h0D, 0);
      step("q_par_full",1, LD,  0, 8'h9B, 1, 8'h0F, 0, 1, 0, 8'h0D, 0);
      step("q_fs",      1, FS,  0, 8'h00, 1, 8'h0F, 0, 1, 0, 8'h0D, 0);
      step("q_laf",     1, LAF, 0, 8'h00, 0, 8'h9B, 1, 1, 0, 8'h0D, 0);
      step("q_chk",     1, RIR, 0, 8'h00, 0, 8'h9B, 1, 0, 0, 8'h0D, 0);
      step("h_valid",   1, DA,  1, 8'h12, 0, 8'h9B, 0, 0, 0, 8'h12, 0);
      step("h_addr3",   1, DA,  1, 8'h0F, 0, 8'h9B, 0, 0, 0, 8'h12, 0);
      step("h_nopv",    1, DA,  0, 8'h21, 0, 8'h9B, 0, 0, 0, 8'h12, 0);
      step("l_hdr",     1, DA,  1, 8'h0D, 0, 8'h9B, 0, 0, 0, 8'h0D, 0);
      step("l_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("l_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("l_p1",      1, LD,  1, 8'h3C, 0, 8'h3C, 0, 0, 0, 8'h0D, 0);
      step("l_par",     1, LD,  0, 8'h94, 0, 8'h94, 1, 1, 0, 8'h0D, 1);
      step("l_chk",     1, RIR, 0, 8'h94, 0, 8'h94, 1, 0, 0, 8'h0D, 1);
      step("r_hdr",     1, DA,  1, 8'h0D, 0, 8'h94, 0, 0, 0, 8'h0D, 0);
      step("r_lfd",     1, LFD, 1, 8'hA5, 0, 8'h0D, 0, 0, 0, 8'h0D, 0);
      step("r_p0",      1, LD,  1, 8'hA5, 0, 8'hA5, 0, 0, 0, 8'h0D, 0);
      step("r_reset",   0, LD,  0, 8'h55, 0, 8'h00, 0, 0, 0, 8'h00, 0);
      step("r_after",   1, NO,  0, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 0);
      repeat (3) @(posedge clock);
      #2;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
